// File: rtl/csel_sync_feeder.sv
// -----------------------------------------------------------------------------
// csel_sync_feeder
// Clocked producer sitting directly upstream of the 4-way click selector.
// Buffers a valid/ready stream of {dest mask, payload} in a small FIFO and
// hands each word to the selector with one drive/free event handshake.
// i_free arrives from the asynchronous click domain and is synchronised here.
//
// Optional feature macro: CSEL_FEEDER_TIMEOUT_EN
//   defined   : DRIVE is abandoned after TIMEOUT_CYC cycles, o_err[1] is sticky
//   undefined : DRIVE waits indefinitely for free, o_err[1] is tied low
// -----------------------------------------------------------------------------
module csel_sync_feeder #(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4,    // power of 2, >= 2
  parameter int SYNC_STAGES = 2,    // >= 2
  parameter int TIMEOUT_CYC = 256   // only meaningful with CSEL_FEEDER_TIMEOUT_EN
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [3:0]                     i_dest,
  input  logic [DATA_WIDTH-1:0]          i_data,
  output logic                           o_drive,
  input  logic                           i_free,
  output logic [DATA_WIDTH+3:0]          o_data,
  output logic [$clog2(FIFO_DEPTH):0]    o_level,
  output logic [1:0]                     o_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = DATA_WIDTH + 4;

  // Handshake FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [WW-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [WW-1:0] w_head;
  logic          w_head_live;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // Ready is withheld while reset is asserted so nothing is accepted mid-reset.
  assign o_ready = !w_full && !rst;
  assign w_push  = i_valid && o_ready;

  // Every IDLE cycle with data pops the head; zero-mask words are simply dropped.
  assign w_pop       = (r_state == ST_IDLE) && !w_empty;
  assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
  assign w_head_live = (w_head[WW-1 -: 4] != 4'b0000);

  assign o_level = r_wr_ptr - r_rd_ptr;

  // Storage array write port
  // NOTE: the storage array has no reset; pointers alone define which entries
  // are valid, and leaving the array unreset lets it map onto plain RAM/flops
  // without a reset tree.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {i_dest, i_data};
    end
  end

  // FIFO pointer update
  // NOTE: all sequential state uses non-blocking assignment so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // i_free synchroniser and rising-edge detector
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_d;
  logic                   w_sync_out;
  logic                   w_free_evt;

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_free_evt = w_sync_out && !r_sync_d;

  // Shift the asynchronous free level through the sync chain, keep one delayed copy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_free};
      r_sync_d <= w_sync_out;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional DRIVE timeout
  // ---------------------------------------------------------------------------
  logic w_timeout;
  logic w_err_to;

`ifdef CSEL_FEEDER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] r_to_cnt;
  logic          r_err_to;

  // Counts cycles spent in DRIVE; held at zero everywhere else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (r_state != ST_DRIVE) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  // The last permitted DRIVE cycle without a free event abandons the word.
  assign w_timeout = (r_state == ST_DRIVE) && !w_free_evt &&
                     (r_to_cnt == TW'(TIMEOUT_CYC - 1));

  // Sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_to <= 1'b0;
    end else if (w_timeout) begin
      r_err_to <= 1'b1;
    end
  end

  assign w_err_to = r_err_to;
`else
  assign w_timeout = 1'b0;
  assign w_err_to  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------

  // Next-state decode
  // NOTE: the default assignment at the top keeps every path assigned, so no
  // latch is inferred for w_state_nxt.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && w_head_live) w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        w_state_nxt = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (w_free_evt || w_timeout) w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Selector-facing outputs
  // ---------------------------------------------------------------------------
  logic [WW-1:0] r_data;
  logic          r_drive;
  logic          r_err_spur;

  // Load the output word only when a live word enters SETUP; held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (w_pop && w_head_live) begin
      r_data <= w_head;
    end
  end

  // Drive is a registered level that is high exactly while the FSM is in DRIVE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drive <= 1'b0;
    end else begin
      r_drive <= (w_state_nxt == ST_DRIVE);
    end
  end

  // Sticky flag for a free event arriving while not waiting for one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_spur <= 1'b0;
    end else if (w_free_evt && (r_state != ST_DRIVE)) begin
      r_err_spur <= 1'b1;
    end
  end

  assign o_data  = r_data;
  assign o_drive = r_drive;
  assign o_err   = {w_err_to, r_err_spur};

endmodule
